toggle_rate_sequencer: RTL and testbench
========================================

# toggle_rate_sequencer

Sequences the 7-bit `TOGGLE_RATE` control that feeds `logic_slr` during power characterisation. Software starts a sweep, and the block steps the toggle rate from a start level to an end level in fixed increments. Each level is held for a programmable dwell time, so the power rails can be measured at every level without software intervention. It sits directly upstream of `logic_slr` in the same clock domain, and its `toggle_rate` output drives that block's `TOGGLE_RATE` input.

## Interface
- `DWELL_WIDTH`, default 24: width of the dwell-count input.
- `RATE_MAX`, default 100: highest legal toggle rate. Every level is clamped to this value.
- `clk`  in  1: sole clock. Shared with `logic_slr`.
- `rst`  in  1: reset, asynchronous, active-high.
- `start`  in  1: single-cycle request. Accepted only in IDLE.
- `abort`  in  1: stops any sweep.
- `mode`  in  2: sweep mode. 0 = single ramp, 1 = looping ramp, 2 = triangle, 3 = hold.
- `rate_start`  in  7: first level.
- `rate_end`  in  7: last level, or the turnaround level in triangle mode.
- `rate_step`  in  7: increment magnitude.
- `dwell`  in  `DWELL_WIDTH`: number of cycles each level is held.
- `toggle_rate`  out  7: level driven to `logic_slr`. Registered.
- `busy`  out  1: high while a sweep runs.
- `done`  out  1: one-cycle pulse when a single-ramp sweep completes.
- `step_strobe`  out  1: one-cycle pulse on every cycle in which `toggle_rate` takes a new level.
- `level_count`  out  8: number of levels presented since `start`. Saturates at 255.

## Operation
- States: IDLE, RUN.
- In IDLE, `start` latches `mode` and the rate and dwell inputs into shadow registers. Changes to the inputs during a sweep have no effect.
- Normalisation is applied at latch time:
  - `rate_start` and `rate_end` are clamped to `RATE_MAX`.
  - `rate_step` = 0 is treated as 1.
  - `dwell` = 0 is treated as 1 (the held value D is at least 1).
- Direction is up if the end level is greater than or equal to the start level, otherwise down.
- Next level:
  - Up direction: next = current + step, computed 8 bits wide, then clamped to the end level. No wrap-around is permitted.
  - Down direction: next = current − step. If the result is below the end level or underflows, the end level is used.
- When the current level reaches the end level, behaviour depends on `mode`:
  - Mode 0: when the final dwell expires, go to IDLE, pulse `done`, and hold `toggle_rate` at the end level.
  - Mode 1: the next level is the start level again. The sweep runs until `abort`.
  - Mode 2: reverse direction. Turnaround levels are presented once, never duplicated. At the start level, reverse again. If start equals end, the block behaves as mode 3.
  - Mode 3: present the start level for the whole sweep and never step, until `abort`.
- If start equals end in mode 0, the block presents one level and pulses `done` after D cycles.
- `abort` handling:
  - From any state, the block goes to IDLE on the next edge and `toggle_rate` becomes 0.
  - No `done` pulse is issued.
  - `abort` has priority over a simultaneous `start` and over simultaneous dwell expiry.
- `start` while `busy` is high is ignored.
- `level_count` clears on an accepted `start` and increments with every `step_strobe`.

## Timing
- Reset values: `toggle_rate` = 0, `busy` = 0, `done` = 0, `step_strobe` = 0, `level_count` = 0. All shadow registers and the dwell counter are 0, and the state is IDLE.
- Reset asserted mid-sweep forces these values immediately, asynchronously.
- `start` sampled at edge T:
  - At T+1: `toggle_rate` = start level, `busy` = 1, `step_strobe` = 1, `level_count` = 1.
- Level k (k = 0, 1, …) appears at T+1+k·D and is held for exactly D cycles. `step_strobe` is high only on the first of those cycles.
- Mode 0 with N levels: at T+1+N·D, `done` = 1 for one cycle, `busy` = 0, and `toggle_rate` = end level (unchanged).
- A new `start` is accepted in the same cycle that `done` is high.
- `abort` sampled at edge A: at A+1, `busy` = 0, `toggle_rate` = 0, and `step_strobe` = 0.
- `toggle_rate` never exceeds `RATE_MAX` in any cycle.

## Test plan
- Mode 0, start = 10, end = 50, step = 10, dwell = 4 → levels 10, 20, 30, 40, 50, each held for exactly 4 cycles. `done` is high at T+21. `level_count` = 5. `toggle_rate` stays 50 afterwards.
- Mode 0, start = 90, end = 5, step = 30, dwell = 2 → levels 90, 60, 30, 5 (the last step is clamped). `done` is high at T+9.
- Mode 2, start = 0, end = 100, step = 40, dwell = 1 → the level sequence 0, 40, 80, 100, 60, 20, 0, 40 repeats. No level is repeated at a turnaround.
- Clamping: `rate_end` = 127, `rate_step` = 0, `dwell` = 0, mode 0, start = 98 → levels 98, 99, 100, one cycle each. `toggle_rate` is never greater than 100.
- Mode 1 with `abort` asserted mid-dwell, together with `start` in the same cycle → `toggle_rate` = 0 and `busy` = 0 on the next cycle. No `done` pulse. A subsequent `start` restarts from the start level.
- Asynchronous `rst` pulse between clock edges during mode 3 → all outputs are 0 immediately. After release, the block stays idle until `start`.

Source files
------------

// File: rtl/toggle_rate_sequencer.sv
// Steps the TOGGLE_RATE level fed to logic_slr from a start level to an end level,
// holding each level for a programmable dwell, with ramp, loop, triangle and hold modes.
module toggle_rate_sequencer #(
  parameter int DWELL_WIDTH = 24,
  parameter int RATE_MAX    = 100
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   abort,
  input  logic [1:0]             mode,
  input  logic [6:0]             rate_start,
  input  logic [6:0]             rate_end,
  input  logic [6:0]             rate_step,
  input  logic [DWELL_WIDTH-1:0] dwell,
  output logic [6:0]             toggle_rate,
  output logic                   busy,
  output logic                   done,
  output logic                   step_strobe,
  output logic [7:0]             level_count
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [6:0] RMAX = 7'(RATE_MAX);

  state_t                 state;
  logic [1:0]             mode_s;
  logic [6:0]             start_s, end_s, step_s;
  logic [DWELL_WIDTH-1:0] dwell_s, cnt;
  logic                   fwd;

  logic [6:0]             lat_start, lat_end, lat_step;
  logic [DWELL_WIDTH-1:0] lat_dwell;
  logic                   ramp_up, dir_up, at_tgt, hold_mode, next_fwd;
  logic [6:0]             tgt, next_rate;

  function automatic logic [6:0] clamp_rate(input logic [6:0] v);
    return (v > RMAX) ? RMAX : v;
  endfunction

  // One step from cur toward tgt, never overshooting tgt and never wrapping.
  function automatic logic [6:0] step_toward(input logic [6:0] cur, input logic [6:0] stp,
                                             input logic [6:0] tg, input logic up);
    logic [7:0] sum;
    sum = {1'b0, cur} + {1'b0, stp};
    if (up)
      return (sum >= {1'b0, tg}) ? tg : sum[6:0];
    else if (cur < stp)
      return tg;
    else
      return ((cur - stp) < tg) ? tg : (cur - stp);
  endfunction

  assign lat_start = clamp_rate(rate_start);
  assign lat_end   = clamp_rate(rate_end);
  assign lat_step  = (rate_step == 7'd0) ? 7'd1 : rate_step;
  assign lat_dwell = (dwell == '0) ? DWELL_WIDTH'(1) : dwell;

  // fwd means travelling from the start level toward the end level.
  assign ramp_up   = (end_s >= start_s);
  assign tgt       = fwd ? end_s : start_s;
  assign dir_up    = fwd ? ramp_up : !ramp_up;
  assign at_tgt    = (toggle_rate == tgt);
  assign hold_mode = (mode_s == 2'd3) || ((mode_s == 2'd2) && (start_s == end_s));

  always_comb begin
    next_rate = toggle_rate;
    next_fwd  = fwd;
    if (!at_tgt) begin
      next_rate = step_toward(toggle_rate, step_s, tgt, dir_up);
    end else if (mode_s == 2'd1) begin
      next_rate = start_s;
    end else if (mode_s == 2'd2) begin
      next_fwd  = !fwd;
      next_rate = step_toward(toggle_rate, step_s, fwd ? start_s : end_s, !dir_up);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      mode_s      <= 2'd0;
      start_s     <= 7'd0;
      end_s       <= 7'd0;
      step_s      <= 7'd0;
      dwell_s     <= '0;
      cnt         <= '0;
      fwd         <= 1'b0;
      toggle_rate <= 7'd0;
      busy        <= 1'b0;
      done        <= 1'b0;
      step_strobe <= 1'b0;
      level_count <= 8'd0;
    end else begin
      step_strobe <= 1'b0;
      done        <= 1'b0;
      if (abort) begin
        state       <= IDLE;
        busy        <= 1'b0;
        toggle_rate <= 7'd0;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              state       <= RUN;
              mode_s      <= mode;
              start_s     <= lat_start;
              end_s       <= lat_end;
              step_s      <= lat_step;
              dwell_s     <= lat_dwell;
              cnt         <= lat_dwell;
              fwd         <= 1'b1;
              toggle_rate <= lat_start;
              busy        <= 1'b1;
              step_strobe <= 1'b1;
              level_count <= 8'd1;
            end
          end
          RUN: begin
            if (cnt > DWELL_WIDTH'(1)) begin
              cnt <= cnt - DWELL_WIDTH'(1);
            end else if (hold_mode) begin
              cnt <= cnt;
            end else if (at_tgt && (mode_s == 2'd0)) begin
              state <= IDLE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              toggle_rate <= next_rate;
              fwd         <= next_fwd;
              cnt         <= dwell_s;
              step_strobe <= 1'b1;
              if (level_count != 8'hFF) level_count <= level_count + 8'd1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_toggle_rate_sequencer.sv
// Randomised bench for toggle_rate_sequencer: expected waveforms come from a level-list
// model built from the sweep rules, compared cycle by cycle.
module tb_toggle_rate_sequencer;

  logic        clk, rst, start, abort;
  logic [1:0]  mode;
  logic [6:0]  rate_start, rate_end, rate_step;
  logic [23:0] dwell;
  logic [6:0]  toggle_rate;
  logic        busy, done, step_strobe;
  logic [7:0]  level_count;

  int n_checks = 0;
  int n_fail   = 0;
  int lev[$];

  toggle_rate_sequencer #(.DWELL_WIDTH(24), .RATE_MAX(100)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .mode(mode),
    .rate_start(rate_start), .rate_end(rate_end), .rate_step(rate_step), .dwell(dwell),
    .toggle_rate(toggle_rate), .busy(busy), .done(done), .step_strobe(step_strobe),
    .level_count(level_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, got, exp);
    end
  endtask

  // Append the levels visited from a to b in increments of st.
  task automatic add_ramp(input int a, input int b, input int st, input bit skip_first);
    int v;
    v = a;
    if (!skip_first) lev.push_back(v);
    while (v != b) begin
      if (b >= a) v = (v + st > b) ? b : v + st;
      else        v = (v - st < b) ? b : v - st;
      lev.push_back(v);
    end
  endtask

  task automatic scramble_inputs();
    mode       = 2'($urandom_range(0, 3));
    rate_start = 7'($urandom_range(0, 127));
    rate_end   = 7'($urandom_range(0, 127));
    rate_step  = 7'($urandom_range(0, 127));
    dwell      = 24'($urandom_range(0, 9));
  endtask

  task automatic check_outputs(input string tag, input int r, input int s, input int b,
                               input int d, input int lc);
    chk({tag, "_rate"},   int'(toggle_rate), r);
    chk({tag, "_strobe"}, int'(step_strobe), s);
    chk({tag, "_busy"},   int'(busy), b);
    chk({tag, "_done"},   int'(done), d);
    chk({tag, "_lcount"}, int'(level_count), lc);
  endtask

  // Called at a negedge; issues start, then checks every following cycle. Mode 0 returns
  // at the negedge of the done cycle; other modes abort after ncyc cycles.
  task automatic run_sweep(input int m, input int rs, input int re, input int rstep,
                           input int dw, input int ncyc, input bit abort_with_start);
    int s, e, st, d, n, total, idx, k, lc;
    bit hold;
    s  = (rs > 100) ? 100 : rs;
    e  = (re > 100) ? 100 : re;
    st = (rstep == 0) ? 1 : rstep;
    d  = (dw == 0) ? 1 : dw;
    hold = (m == 3) || (m == 2 && s == e);
    lev.delete();
    if (hold) lev.push_back(s);
    else if (m == 0) add_ramp(s, e, st, 1'b0);
    else if (m == 1) while (lev.size() < ncyc + 2) add_ramp(s, e, st, 1'b0);
    else begin
      add_ramp(s, e, st, 1'b0);
      while (lev.size() < ncyc + 2) begin
        add_ramp(e, s, st, 1'b1);
        add_ramp(s, e, st, 1'b1);
      end
    end
    n     = lev.size();
    total = (m == 0) ? n * d + 1 : ncyc;

    mode = 2'(m); rate_start = 7'(rs); rate_end = 7'(re); rate_step = 7'(rstep);
    dwell = 24'(dw); abort = 1'b0; start = 1'b1;
    for (int c = 1; c <= total; c++) begin
      @(negedge clk);
      start = 1'b0;
      scramble_inputs();
      idx = c - 1;
      chk("rate_max", int'(toggle_rate <= 7'd100), 1);
      if (m == 0 && idx == n * d) begin
        check_outputs("done_cyc", e, 0, 0, 1, n);
      end else begin
        k  = hold ? 0 : idx / d;
        lc = (k + 1 > 255) ? 255 : k + 1;
        check_outputs("run", lev[k], hold ? int'(idx == 0) : int'(idx % d == 0), 1, 0, lc);
      end
      if (m != 0 || c <= n * d) start = 1'($urandom_range(0, 1));
    end
    if (m != 0) begin
      abort = 1'b1;
      start = abort_with_start;
      @(negedge clk);
      chk("abort_busy",   int'(busy), 0);
      chk("abort_rate",   int'(toggle_rate), 0);
      chk("abort_strobe", int'(step_strobe), 0);
      chk("abort_done",   int'(done), 0);
      abort = 1'b0;
      start = 1'b0;
    end
  endtask

  task automatic idle_check(input int ncyc, input int exp_rate, input int exp_lc);
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      check_outputs("idle", exp_rate, 0, 0, 0, exp_lc);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0;
    mode = 2'd0; rate_start = 7'd0; rate_end = 7'd0; rate_step = 7'd0; dwell = 24'd0;
    @(negedge clk);
    check_outputs("reset", 0, 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b0;
    idle_check(2, 0, 0);

    run_sweep(0, 10, 50, 10, 4, 0, 1'b0);
    idle_check(3, 50, 5);
    run_sweep(0, 90, 5, 30, 2, 0, 1'b0);
    run_sweep(2, 0, 100, 40, 1, 30, 1'b0);
    run_sweep(0, 98, 127, 0, 0, 0, 1'b0);
    idle_check(2, 100, 3);
    run_sweep(1, 10, 60, 25, 3, 17, 1'b1);
    idle_check(2, 0, 6);
    run_sweep(1, 10, 60, 25, 3, 8, 1'b0);

    for (int i = 0; i < 30; i++) begin
      run_sweep($urandom_range(0, 3), $urandom_range(0, 127), $urandom_range(0, 127),
                $urandom_range(0, 45), $urandom_range(0, 3), $urandom_range(3, 60),
                1'($urandom_range(0, 1)));
    end

    // Asynchronous reset between edges during a hold-mode sweep.
    mode = 2'd3; rate_start = 7'd42; rate_end = 7'd80; rate_step = 7'd5; dwell = 24'd2;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("hold_rate", int'(toggle_rate), 42);
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1 check_outputs("async_rst", 0, 0, 0, 0, 0);
    #1 rst = 1'b0;
    idle_check(5, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: bench did not finish, got running expected finished");
    $fatal(1);
  end

endmodule
